multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: IDLE/FETCH/DECODE/EXEC/MEM/WB sequencer with datapath strobes.
// Optional retired-instruction counter is built only when INSTR_CNT_EN is defined.
module multicycle_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        run_i,
  input  logic [3:0]  op_i,
  input  logic        zero_i,
  input  logic        mem_rdy_i,
  output logic        memreq_o,
  output logic        iord_o,
  output logic        irwrite_o,
  output logic        pcwrite_o,
  output logic        jump_o,
  output logic        branch_o,
  output logic [2:0]  aluc_o,
  output logic        alusrcb_o,
  output logic        writemem_o,
  output logic        writereg_o,
  output logic        memtoreg_o,
  output logic        regdes_o,
  output logic        wrflag_o,
  output logic [2:0]  state_o,
  output logic [15:0] instr_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  state_e     state_q;
  logic [3:0] op_q;

  logic   is_jmp_s, is_br_s, is_lw_s, is_sw_s, br_taken_s;
  state_e after_s;

  function automatic logic [2:0] alu_func(input logic [3:0] op);
    case (op)
      4'h0, 4'h8:               alu_func = 3'b000;
      4'h3, 4'hD, 4'hE:         alu_func = 3'b001;
      4'h5:                     alu_func = 3'b010;
      4'h4, 4'hF:               alu_func = 3'b011;
      4'h6:                     alu_func = 3'b100;
      4'h2, 4'hA, 4'hB, 4'hC:   alu_func = 3'b101;
      4'h1, 4'h9:               alu_func = 3'b110;
      4'h7:                     alu_func = 3'b111;
      default:                  alu_func = 3'b000;
    endcase
  endfunction

  assign is_jmp_s   = (op_q == 4'h7);
  assign is_br_s    = (op_q == 4'hD) || (op_q == 4'hE) || (op_q == 4'hF);
  assign is_lw_s    = (op_q == 4'hB);
  assign is_sw_s    = (op_q == 4'hC);
  assign br_taken_s = ((op_q == 4'hD) && zero_i) ||
                      (((op_q == 4'hE) || (op_q == 4'hF)) && !zero_i);
  // RUN is only consulted at an instruction boundary
  assign after_s    = run_i ? S_FETCH : S_IDLE;

  // State sequencing and opcode latch
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      op_q    <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE:   state_q <= run_i ? S_FETCH : S_IDLE;
        S_FETCH:  state_q <= mem_rdy_i ? S_DECODE : S_FETCH;
        S_DECODE: begin
          op_q    <= op_i;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (is_jmp_s || is_br_s) begin
            state_q <= after_s;
          end else if (is_lw_s || is_sw_s) begin
            state_q <= S_MEM;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_rdy_i) begin
            state_q <= is_sw_s ? after_s : S_WB;
          end else begin
            state_q <= S_MEM;
          end
        end
        S_WB:     state_q <= after_s;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Strobe decode; strobes are suppressed while reset is asserted so an
  // in-flight memory handshake cannot produce a PC or register write
  always_comb begin
    memreq_o   = 1'b0;
    iord_o     = 1'b0;
    irwrite_o  = 1'b0;
    pcwrite_o  = 1'b0;
    jump_o     = 1'b0;
    branch_o   = 1'b0;
    aluc_o     = 3'b000;
    alusrcb_o  = 1'b0;
    writemem_o = 1'b0;
    writereg_o = 1'b0;
    memtoreg_o = 1'b0;
    regdes_o   = 1'b0;
    wrflag_o   = 1'b0;
    if (rst_ni) begin
      case (state_q)
        S_FETCH: begin
          memreq_o  = 1'b1;
          irwrite_o = mem_rdy_i;
          pcwrite_o = mem_rdy_i;
        end
        S_EXEC: begin
          aluc_o    = alu_func(op_q);
          alusrcb_o = (op_q >= 4'h8) && (op_q <= 4'hC);
          jump_o    = is_jmp_s;
          branch_o  = is_br_s && br_taken_s;
          pcwrite_o = is_jmp_s || (is_br_s && br_taken_s);
        end
        S_MEM: begin
          memreq_o   = 1'b1;
          iord_o     = 1'b1;
          writemem_o = is_sw_s;
        end
        S_WB: begin
          writereg_o = 1'b1;
          memtoreg_o = is_lw_s;
          regdes_o   = (op_q <= 4'h6);
          wrflag_o   = (op_q == 4'h2) || (op_q == 4'h3) || (op_q == 4'h5) ||
                       (op_q == 4'h6) || (op_q == 4'hA);
        end
        default: begin
          memreq_o = 1'b0;
        end
      endcase
    end else begin
      pcwrite_o  = 1'b0;
      writereg_o = 1'b0;
    end
  end

  assign state_o = state_q;

`ifdef INSTR_CNT_EN
  logic        retire_s;
  logic [15:0] cnt_q, cnt_d;

  assign retire_s = ((state_q == S_EXEC) && (is_jmp_s || is_br_s)) ||
                    ((state_q == S_MEM) && is_sw_s && mem_rdy_i) ||
                    (state_q == S_WB);
  assign cnt_d    = retire_s ? (cnt_q + 16'd1) : cnt_q;

  // Retired-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_cnt_o = cnt_q;
`else
  assign instr_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized
// instruction streams checked against a per-instruction cycle-sequence model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, run, zero, mem_rdy;
  logic [3:0]  op;
  logic        memreq, iord, irwrite, pcwrite, jump, branch;
  logic [2:0]  aluc;
  logic        alusrcb, writemem, writereg, memtoreg, regdes, wrflag;
  logic [2:0]  state;
  logic [15:0] instr_cnt;
  logic [14:0] obs_vec;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] model_cnt = 16'd0;
  bit          in_fetch = 1'b0;
  logic [2:0]  alu_tab [16];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run), .op_i(op), .zero_i(zero),
    .mem_rdy_i(mem_rdy), .memreq_o(memreq), .iord_o(iord), .irwrite_o(irwrite),
    .pcwrite_o(pcwrite), .jump_o(jump), .branch_o(branch), .aluc_o(aluc),
    .alusrcb_o(alusrcb), .writemem_o(writemem), .writereg_o(writereg),
    .memtoreg_o(memtoreg), .regdes_o(regdes), .wrflag_o(wrflag),
    .state_o(state), .instr_cnt_o(instr_cnt)
  );

  assign obs_vec = {memreq, iord, irwrite, pcwrite, jump, branch, aluc,
                    alusrcb, writemem, writereg, memtoreg, regdes, wrflag};

  function automatic logic [14:0] mk(input logic mreq, input logic ird, input logic irw,
                                     input logic pcw, input logic jmp, input logic br,
                                     input logic [2:0] alu, input logic srcb, input logic wmem,
                                     input logic wreg, input logic m2r, input logic rdes,
                                     input logic wfl);
    return {mreq, ird, irw, pcw, jmp, br, alu, srcb, wmem, wreg, m2r, rdes, wfl};
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef INSTR_CNT_EN
    return model_cnt;
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic rnd_run(input bit low);
    return low ? 1'b0 : 1'($urandom);
  endfunction

  task automatic drv(input logic r, input logic [3:0] o, input logic z, input logic rdy);
    run = r; op = o; zero = z; mem_rdy = rdy;
  endtask

  // Compare at the falling edge, then advance to just after the next rising edge
  task automatic chk(input string tag, input logic [2:0] es, input logic [14:0] ev);
    @(negedge clk);
    n_tests++;
    assert (state === es) else begin
      n_fail++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state, es);
    end
    n_tests++;
    assert (obs_vec === ev) else begin
      n_fail++;
      $error("FAIL %s outputs observed=%b expected=%b", tag, obs_vec, ev);
    end
    n_tests++;
    assert (instr_cnt === exp_cnt()) else begin
      n_fail++;
      $error("FAIL %s instr_cnt observed=%h expected=%h", tag, instr_cnt, exp_cnt());
    end
    @(posedge clk);
    #1;
  endtask

  // Bring the controller from IDLE into FETCH (no-op if already fetching)
  task automatic go();
    int k;
    if (!in_fetch) begin
      k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++) begin
        drv(1'b0, 4'($urandom), 1'($urandom), 1'($urandom));
        chk("idle", 3'd0, 15'd0);
      end
      drv(1'b1, 4'($urandom), 1'($urandom), 1'($urandom));
      chk("idle_go", 3'd0, 15'd0);
      in_fetch = 1'b1;
    end
  endtask

  // One whole instruction, starting in the first FETCH cycle
  task automatic do_instr(input logic [3:0] o, input logic z, input int fw, input int mw,
                          input logic run_end, input bit mid_low);
    logic is_sw, is_lw, fin_e, taken, srcb;
    is_sw = (o == 4'hC);
    is_lw = (o == 4'hB);
    fin_e = (o == 4'h7) || (o >= 4'hD);
    taken = (o == 4'hD) ? z : ((o >= 4'hE) ? ~z : 1'b0);
    srcb  = (o >= 4'h8) && (o <= 4'hC);
    for (int i = 0; i < fw; i++) begin
      drv(rnd_run(mid_low), o, 1'($urandom), 1'b0);
      chk("fetch_wait", 3'd1, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    drv(rnd_run(mid_low), o, 1'($urandom), 1'b1);
    chk("fetch_rdy", 3'd1, mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drv(rnd_run(mid_low), o, 1'($urandom), 1'($urandom));
    chk("decode", 3'd2, 15'd0);
    // OP is scrambled from here on: later phases must use the latched opcode
    drv(fin_e ? run_end : rnd_run(mid_low), 4'($urandom), z, 1'($urandom));
    chk("exec", 3'd3, mk(1'b0, 1'b0, 1'b0, (o == 4'h7) || taken, o == 4'h7, taken,
                         alu_tab[o], srcb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    if (is_sw || is_lw) begin
      for (int i = 0; i < mw; i++) begin
        drv(rnd_run(mid_low), 4'($urandom), 1'($urandom), 1'b0);
        chk("mem_wait", 3'd4, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000,
                                 1'b0, is_sw, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      drv(is_sw ? run_end : rnd_run(mid_low), 4'($urandom), 1'($urandom), 1'b1);
      chk("mem_rdy", 3'd4, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000,
                              1'b0, is_sw, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    if (!fin_e && !is_sw) begin
      drv(run_end, 4'($urandom), 1'($urandom), 1'($urandom));
      chk("wb", 3'd5, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0,
                         1'b1, is_lw, o <= 4'h6,
                         (o == 4'h2) || (o == 4'h3) || (o == 4'h5) ||
                         (o == 4'h6) || (o == 4'hA)));
    end
    model_cnt = model_cnt + 16'd1;
    in_fetch  = run_end;
  endtask

  initial begin
    alu_tab[0]  = 3'b000; alu_tab[1]  = 3'b110; alu_tab[2]  = 3'b101; alu_tab[3]  = 3'b001;
    alu_tab[4]  = 3'b011; alu_tab[5]  = 3'b010; alu_tab[6]  = 3'b100; alu_tab[7]  = 3'b111;
    alu_tab[8]  = 3'b000; alu_tab[9]  = 3'b110; alu_tab[10] = 3'b101; alu_tab[11] = 3'b101;
    alu_tab[12] = 3'b101; alu_tab[13] = 3'b001; alu_tab[14] = 3'b001; alu_tab[15] = 3'b011;

    // Reset: state, strobes and counter all zero
    rst_n = 1'b0;
    drv(1'b1, 4'hF, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("reset", 3'd0, 15'd0);
    rst_n = 1'b1;
    model_cnt = 16'd0;
    in_fetch  = 1'b0;

    // ADD with immediate memory readiness
    go();
    do_instr(4'h2, 1'b0, 0, 0, 1'b1, 1'b0);
    // LW with two memory wait cycles
    do_instr(4'hB, 1'b1, 0, 2, 1'b1, 1'b0);
    // Branches: BEQ taken, BNE not taken, JMPB taken, JMP
    do_instr(4'hD, 1'b1, 1, 0, 1'b1, 1'b0);
    do_instr(4'hE, 1'b1, 0, 0, 1'b1, 1'b0);
    do_instr(4'hF, 1'b0, 0, 0, 1'b1, 1'b0);
    do_instr(4'h7, 1'b0, 0, 0, 1'b1, 1'b0);
    // SW with RUN low from decode onward: completes, then parks in IDLE
    do_instr(4'hC, 1'b0, 0, 1, 1'b0, 1'b1);
    go();

    // Reset during a fetch wait: no PC/IR strobes, then IDLE
    drv(1'b1, 4'h2, 1'b0, 1'b0);
    chk("rst_fetch_wait", 3'd1, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b0;
    drv(1'b1, 4'h2, 1'b0, 1'b1);
    chk("rst_cycle", 3'd1, 15'd0);
    rst_n = 1'b1;
    model_cnt = 16'd0;
    in_fetch  = 1'b0;
    drv(1'b0, 4'h2, 1'b0, 1'b1);
    chk("after_rst", 3'd0, 15'd0);

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      go();
      do_instr(4'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
               ($urandom_range(0, 3) != 0), 1'b0);
    end

`ifdef INSTR_CNT_EN
    // Counter wrap from FFFF to 0000
    go();
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    model_cnt = 16'hFFFF;
    do_instr(4'h7, 1'b0, 0, 0, 1'b1, 1'b0);
    drv(1'b1, 4'h0, 1'b0, 1'b0);
    chk("cnt_wrap", 3'd1, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
